// File: rtl/alu_simd_scheduler_if.sv
// Bundle of request, response and ALU-side signals for the SIMD ALU issue scheduler.
// slave = scheduler side, master = requesters / response sink / ALU side.
interface alu_simd_scheduler_if #(
  parameter int Width = 8
);
  logic [1:0]         req_valid;
  logic [1:0]         req_ready;
  logic [5:0]         req_cmd;
  logic [1:0]         req_chain;
  logic [2*Width-1:0] req_w;
  logic [2*Width-1:0] req_x;
  logic [2*Width-1:0] req_y;
  logic [2*Width-1:0] req_z;

  logic [Width-1:0]   alu_W;
  logic [Width-1:0]   alu_X;
  logic [Width-1:0]   alu_Y;
  logic [Width-1:0]   alu_Z;
  logic [1:0]         alu_op;
  logic               alu_Z_controller;
  logic               alu_S_controller;
  logic               alu_W_X_Y_controller;
  logic [1:0]         alu_CIN_W_X_Y_CIN;
  logic [1:0]         alu_CIN_Z_W_X_Y_CIN;
  logic               alu_result_SIDM_carry_in;
  logic [Width-1:0]   alu_S;
  logic [1:0]         alu_COUT_W_X_Y_CIN;
  logic [1:0]         alu_COUT_Z_W_X_Y_CIN;

  logic               rsp_valid;
  logic               rsp_ready;
  logic               rsp_id;
  logic [Width-1:0]   rsp_data;
  logic [3:0]         rsp_cout;

  modport slave (
    input  req_valid, req_cmd, req_chain, req_w, req_x, req_y, req_z,
    output req_ready,
    output alu_W, alu_X, alu_Y, alu_Z, alu_op,
    output alu_Z_controller, alu_S_controller, alu_W_X_Y_controller,
    output alu_CIN_W_X_Y_CIN, alu_CIN_Z_W_X_Y_CIN, alu_result_SIDM_carry_in,
    input  alu_S, alu_COUT_W_X_Y_CIN, alu_COUT_Z_W_X_Y_CIN,
    output rsp_valid, rsp_id, rsp_data, rsp_cout,
    input  rsp_ready
  );

  modport master (
    output req_valid, req_cmd, req_chain, req_w, req_x, req_y, req_z,
    input  req_ready,
    input  alu_W, alu_X, alu_Y, alu_Z, alu_op,
    input  alu_Z_controller, alu_S_controller, alu_W_X_Y_controller,
    input  alu_CIN_W_X_Y_CIN, alu_CIN_Z_W_X_Y_CIN, alu_result_SIDM_carry_in,
    output alu_S, alu_COUT_W_X_Y_CIN, alu_COUT_Z_W_X_Y_CIN,
    input  rsp_valid, rsp_id, rsp_data, rsp_cout,
    output rsp_ready
  );
endinterface

// File: rtl/alu_simd_scheduler.sv
// Two-requester round-robin issue controller for a shared SIMD ALU.
// Stage A holds the issued op and drives the ALU; stage R holds the response.
module alu_simd_scheduler #(
  parameter int Width = 8
) (
  input logic                 clk,
  input logic                 reset,
  alu_simd_scheduler_if.slave bus
);

  localparam logic [2:0] CmdAdd  = 3'd0;
  localparam logic [2:0] CmdSub  = 3'd1;
  localparam logic [2:0] CmdXor3 = 3'd2;
  localparam logic [2:0] CmdAnd  = 3'd3;
  localparam logic [2:0] CmdOr   = 3'd4;
  localparam logic [2:0] CmdAndn = 3'd5;
  localparam logic [2:0] CmdNand = 3'd6;
  localparam logic [2:0] CmdNor  = 3'd7;

  typedef struct packed {
    logic [1:0] op;
    logic       zc;
    logic       sc;
    logic       wxyc;
  } ctrl_t;

  function automatic ctrl_t decode(input logic [2:0] cmd);
    ctrl_t c;
    c = '0;
    case (cmd)
      CmdAdd:  c = '{op: 2'b00, zc: 1'b0, sc: 1'b0, wxyc: 1'b0};
      CmdSub:  c = '{op: 2'b00, zc: 1'b0, sc: 1'b1, wxyc: 1'b1};
      CmdXor3: c = '{op: 2'b01, zc: 1'b0, sc: 1'b0, wxyc: 1'b0};
      CmdAnd:  c = '{op: 2'b10, zc: 1'b0, sc: 1'b0, wxyc: 1'b0};
      CmdOr:   c = '{op: 2'b11, zc: 1'b0, sc: 1'b0, wxyc: 1'b0};
      CmdAndn: c = '{op: 2'b10, zc: 1'b1, sc: 1'b0, wxyc: 1'b0};
      CmdNand: c = '{op: 2'b10, zc: 1'b0, sc: 1'b1, wxyc: 1'b0};
      CmdNor:  c = '{op: 2'b11, zc: 1'b0, sc: 1'b1, wxyc: 1'b0};
      default: c = '0;
    endcase
    return c;
  endfunction

  // stage A
  logic             valid_a;
  logic [Width-1:0] a_w, a_x, a_y, a_z;
  ctrl_t            a_ctrl;
  logic [2:0]       a_cmd;
  logic             a_id;
  logic             a_chain;

  // stage R
  logic             valid_r;
  logic [Width-1:0] r_data;
  logic [3:0]       r_cout;
  logic             r_id;

  // per-requester {cout_z[1:0], cout_wxy[1:0]}
  logic [3:0]       carry_reg [2];
  logic             ptr;

  logic             adv_r, adv_a, accept, a_leave, a_arith;
  logic [1:0]       grant;
  logic             grant_id;
  logic             fire;
  logic [2:0]       sel_cmd;
  logic             sel_chain;
  logic [Width-1:0] sel_w, sel_x, sel_y, sel_z;
  logic [3:0]       cin_sel;

  always_comb begin
    adv_r   = !valid_r || bus.rsp_ready;
    adv_a   = adv_r;
    accept  = !valid_a || adv_a;
    a_leave = valid_a && adv_a;
    a_arith = (a_cmd == CmdAdd) || (a_cmd == CmdSub);
  end

  always_comb begin
    grant    = 2'b00;
    grant_id = 1'b0;
    if (accept) begin
      if (!ptr) begin
        if (bus.req_valid[0]) begin
          grant    = 2'b01;
          grant_id = 1'b0;
        end else if (bus.req_valid[1]) begin
          grant    = 2'b10;
          grant_id = 1'b1;
        end
      end else begin
        if (bus.req_valid[1]) begin
          grant    = 2'b10;
          grant_id = 1'b1;
        end else if (bus.req_valid[0]) begin
          grant    = 2'b01;
          grant_id = 1'b0;
        end
      end
    end
    fire = |grant;
  end

  always_comb begin
    sel_cmd   = grant_id ? bus.req_cmd[5:3] : bus.req_cmd[2:0];
    sel_chain = bus.req_chain[grant_id];
    sel_w     = grant_id ? bus.req_w[2*Width-1:Width] : bus.req_w[Width-1:0];
    sel_x     = grant_id ? bus.req_x[2*Width-1:Width] : bus.req_x[Width-1:0];
    sel_y     = grant_id ? bus.req_y[2*Width-1:Width] : bus.req_y[Width-1:0];
    sel_z     = grant_id ? bus.req_z[2*Width-1:Width] : bus.req_z[Width-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_a <= 1'b0;
      a_w     <= '0;
      a_x     <= '0;
      a_y     <= '0;
      a_z     <= '0;
      a_ctrl  <= '0;
      a_cmd   <= '0;
      a_id    <= 1'b0;
      a_chain <= 1'b0;
    end else if (accept) begin
      valid_a <= fire;
      if (fire) begin
        a_w     <= sel_w;
        a_x     <= sel_x;
        a_y     <= sel_y;
        a_z     <= sel_z;
        a_ctrl  <= decode(sel_cmd);
        a_cmd   <= sel_cmd;
        a_id    <= grant_id;
        a_chain <= sel_chain;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_r <= 1'b0;
      r_data  <= '0;
      r_cout  <= '0;
      r_id    <= 1'b0;
    end else if (adv_r) begin
      valid_r <= valid_a;
      if (valid_a) begin
        r_data <= bus.alu_S;
        r_cout <= {bus.alu_COUT_Z_W_X_Y_CIN, bus.alu_COUT_W_X_Y_CIN};
        r_id   <= a_id;
      end
    end
  end

  // Written on the same edge the next op enters A, so a chained follower sees it directly.
  always_ff @(posedge clk) begin
    if (reset) begin
      carry_reg[0] <= '0;
      carry_reg[1] <= '0;
    end else if (a_leave && a_arith) begin
      carry_reg[a_id] <= {bus.alu_COUT_Z_W_X_Y_CIN, bus.alu_COUT_W_X_Y_CIN};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr <= 1'b0;
    end else if (fire) begin
      ptr <= ~grant_id;
    end
  end

  always_comb begin
    cin_sel = '0;
    if (valid_a && (a_cmd == CmdAdd) && a_chain) begin
      cin_sel = carry_reg[a_id];
    end
  end

  assign bus.req_ready                = grant;
  assign bus.alu_W                    = a_w;
  assign bus.alu_X                    = a_x;
  assign bus.alu_Y                    = a_y;
  assign bus.alu_Z                    = a_z;
  assign bus.alu_op                   = a_ctrl.op;
  assign bus.alu_Z_controller         = a_ctrl.zc;
  assign bus.alu_S_controller         = a_ctrl.sc;
  assign bus.alu_W_X_Y_controller     = a_ctrl.wxyc;
  assign bus.alu_CIN_W_X_Y_CIN        = cin_sel[1:0];
  assign bus.alu_CIN_Z_W_X_Y_CIN      = cin_sel[3:2];
  assign bus.alu_result_SIDM_carry_in = 1'b0;
  assign bus.rsp_valid                = valid_r;
  assign bus.rsp_id                   = r_id;
  assign bus.rsp_data                 = r_data;
  assign bus.rsp_cout                 = r_cout;

endmodule

// File: tb/tb_alu_simd_scheduler.sv
// Bench for alu_simd_scheduler: behavioural ALU stand-in plus a queue-based response model.
module tb_alu_simd_scheduler;
  localparam int W = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  alu_simd_scheduler_if #(.Width(W)) bus();
  alu_simd_scheduler #(.Width(W)) dut (.clk(clk), .reset(reset), .bus(bus));

  // ALU stand-in driven purely by the control outputs
  logic [9:0] m_s1, m_s2;
  logic [7:0] m_a8, m_zz, m_res;
  always_comb begin
    m_zz  = bus.alu_Z_controller ? ~bus.alu_Z : bus.alu_Z;
    m_s1  = 10'(bus.alu_W) + 10'(bus.alu_X) + 10'(bus.alu_Y) + 10'(bus.alu_CIN_W_X_Y_CIN);
    m_a8  = bus.alu_W_X_Y_controller ? ~m_s1[7:0] : m_s1[7:0];
    m_s2  = 10'(m_a8) + 10'(m_zz) + 10'(bus.alu_CIN_Z_W_X_Y_CIN);
    m_res = '0;
    bus.alu_COUT_W_X_Y_CIN   = 2'b00;
    bus.alu_COUT_Z_W_X_Y_CIN = 2'b00;
    case (bus.alu_op)
      2'b00: begin
        m_res = m_s2[7:0];
        bus.alu_COUT_W_X_Y_CIN   = m_s1[9:8];
        bus.alu_COUT_Z_W_X_Y_CIN = m_s2[9:8];
      end
      2'b01:   m_res = bus.alu_X ^ bus.alu_Y ^ m_zz;
      2'b10:   m_res = bus.alu_X & m_zz;
      default: m_res = bus.alu_X | m_zz;
    endcase
    bus.alu_S = bus.alu_S_controller ? ~m_res : m_res;
  end

  typedef struct {
    logic       id;
    logic [7:0] data;
    logic [3:0] cout;
    int         age;
  } exp_t;

  exp_t       q[$];
  logic       ptr_m;
  logic [3:0] carry_m [2];
  int         checks;
  int         errors;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Returns {cout_z, cout_wxy, data} for a command, from its arithmetic meaning.
  function automatic logic [11:0] ref_op(input logic [2:0] cmd, input logic [7:0] w, x, y, z,
                                         input logic [3:0] cin);
    int sum1, sum2;
    logic [7:0] d;
    logic [3:0] co;
    co = '0;
    d  = '0;
    sum1 = 0;
    sum2 = 0;
    case (cmd)
      3'd0: begin
        sum1 = w + x + y + cin[1:0];
        sum2 = (sum1 % 256) + z + cin[3:2];
        d    = 8'(sum2);
        co   = {2'(sum2 / 256), 2'(sum1 / 256)};
      end
      3'd1: begin
        sum1 = w + x + y;
        d    = 8'(sum1 - z);
        co   = {2'((255 - (sum1 % 256) + z) / 256), 2'(sum1 / 256)};
      end
      3'd2: d = x ^ y ^ z;
      3'd3: d = x & z;
      3'd4: d = x | z;
      3'd5: d = x & ~z;
      3'd6: d = ~(x & z);
      default: d = ~(x | z);
    endcase
    return {co, d};
  endfunction

  // One clock: check pre-edge outputs against the model, advance the model, cross the edge.
  task automatic step();
    logic [1:0]  eg;
    logic        gid, can, ev, ch;
    logic [2:0]  c;
    logic [3:0]  cin;
    logic [11:0] r;
    exp_t        e;
    #1;
    ev  = (q.size() > 0) && (q[0].age >= 1);
    can = (q.size() < 2) || bus.rsp_ready;
    eg  = 2'b00;
    gid = 1'b0;
    if (can && !reset) begin
      if (bus.req_valid[ptr_m]) begin
        gid = ptr_m;
      end else if (bus.req_valid[~ptr_m]) begin
        gid = ~ptr_m;
      end
      if (bus.req_valid != 2'b00) eg = gid ? 2'b10 : 2'b01;
    end
    chk_eq("req_ready", bus.req_ready, eg);
    chk_eq("rsp_valid", bus.rsp_valid, ev);
    chk_eq("sidm_cin", bus.alu_result_SIDM_carry_in, 0);
    if (ev) begin
      chk_eq("rsp_id", bus.rsp_id, q[0].id);
      chk_eq("rsp_data", bus.rsp_data, q[0].data);
      chk_eq("rsp_cout", bus.rsp_cout, q[0].cout);
    end
    if (reset) begin
      q.delete();
      ptr_m = 1'b0;
      carry_m[0] = '0;
      carry_m[1] = '0;
    end else begin
      if (ev && bus.rsp_ready) void'(q.pop_front());
      foreach (q[i]) q[i].age = q[i].age + 1;
      if (eg != 2'b00) begin
        c   = bus.req_cmd[3*gid +: 3];
        ch  = bus.req_chain[gid];
        cin = (c == 3'd0 && ch) ? carry_m[gid] : 4'h0;
        r   = ref_op(c, bus.req_w[8*gid +: 8], bus.req_x[8*gid +: 8],
                     bus.req_y[8*gid +: 8], bus.req_z[8*gid +: 8], cin);
        if (c <= 3'd1) carry_m[gid] = r[11:8];
        e.id   = gid;
        e.data = r[7:0];
        e.cout = r[11:8];
        e.age  = 0;
        q.push_back(e);
        ptr_m = ~gid;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_req(input int i, input logic [2:0] cmd, input logic chain,
                         input logic [7:0] w, x, y, z);
    bus.req_valid[i]      = 1'b1;
    bus.req_cmd[3*i +: 3] = cmd;
    bus.req_chain[i]      = chain;
    bus.req_w[8*i +: 8]   = w;
    bus.req_x[8*i +: 8]   = x;
    bus.req_y[8*i +: 8]   = y;
    bus.req_z[8*i +: 8]   = z;
  endtask

  task automatic idle();
    bus.req_valid = 2'b00;
  endtask

  // Issue one op on requester 0 into an empty pipe; report A-stage CINs and the response.
  task automatic run_one(input logic [2:0] cmd, input logic chain, input logic [7:0] w, x, y, z,
                         output logic [1:0] cinw, output logic [1:0] cinz,
                         output logic [7:0] d, output logic [3:0] co, output logic id);
    bus.rsp_ready = 1'b1;
    set_req(0, cmd, chain, w, x, y, z);
    step();
    idle();
    #1;
    cinw = bus.alu_CIN_W_X_Y_CIN;
    cinz = bus.alu_CIN_Z_W_X_Y_CIN;
    step();
    #1;
    d  = bus.rsp_data;
    co = bus.rsp_cout;
    id = bus.rsp_id;
    step();
  endtask

  logic [1:0] cw, cz;
  logic [7:0] d;
  logic [3:0] co;
  logic       id;

  initial begin
    checks = 0;
    errors = 0;
    ptr_m = 1'b0;
    carry_m[0] = '0;
    carry_m[1] = '0;
    reset = 1'b1;
    bus.req_valid = '0;
    bus.req_cmd   = '0;
    bus.req_chain = '0;
    bus.req_w = '0;
    bus.req_x = '0;
    bus.req_y = '0;
    bus.req_z = '0;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    step();
    step();
    reset = 1'b0;
    #1;
    chk_eq("rst_alu_w", bus.alu_W, 0);
    chk_eq("rst_alu_x", bus.alu_X, 0);
    chk_eq("rst_alu_y", bus.alu_Y, 0);
    chk_eq("rst_alu_z", bus.alu_Z, 0);
    chk_eq("rst_alu_ctl", {bus.alu_op, bus.alu_Z_controller, bus.alu_S_controller,
                           bus.alu_W_X_Y_controller}, 0);
    chk_eq("rst_alu_cin", {bus.alu_CIN_Z_W_X_Y_CIN, bus.alu_CIN_W_X_Y_CIN}, 0);
    chk_eq("rst_rsp", {bus.rsp_valid, bus.rsp_id, bus.rsp_data, bus.rsp_cout}, 0);

    // both requesters contend; req1 runs a chained ADD sequence
    for (int k = 0; k < 6; k++) begin
      set_req(0, 3'd0, 1'b1, 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
      set_req(1, 3'd0, 1'b1, 8'hFF, 8'hFF, 8'hFF, 8'hFF);
      #1;
      chk_eq("rr_grant", bus.req_ready, (k % 2 == 1) ? 2'b10 : 2'b01);
      step();
    end
    idle();
    step();
    step();

    run_one(3'd0, 1'b0, 8'd1, 8'd2, 8'd3, 8'd4, cw, cz, d, co, id);
    chk_eq("add_basic", d, 8'h0A);
    chk_eq("add_basic_cout", co, 4'h0);
    chk_eq("add_basic_id", id, 1'b0);
    run_one(3'd0, 1'b0, 8'hFF, 8'hFF, 8'hFF, 8'hFF, cw, cz, d, co, id);
    chk_eq("add_ff", d, 8'hFC);
    chk_eq("add_ff_cout", co, 4'b0110);
    run_one(3'd0, 1'b1, 8'h00, 8'h00, 8'h00, 8'h00, cw, cz, d, co, id);
    chk_eq("chain_cin_wxy", cw, 2'd2);
    chk_eq("chain_cin_z", cz, 2'd1);
    chk_eq("chain_data", d, 8'h03);
    run_one(3'd1, 1'b0, 8'd10, 8'd0, 8'd0, 8'd3, cw, cz, d, co, id);
    chk_eq("sub", d, 8'h07);
    run_one(3'd7, 1'b0, 8'h00, 8'hF0, 8'h00, 8'h0F, cw, cz, d, co, id);
    chk_eq("nor", d, 8'h00);
    run_one(3'd5, 1'b0, 8'h00, 8'hFF, 8'h00, 8'h0F, cw, cz, d, co, id);
    chk_eq("andn", d, 8'hF0);
    run_one(3'd2, 1'b0, 8'h00, 8'hAA, 8'hFF, 8'h0F, cw, cz, d, co, id);
    chk_eq("xor3", d, 8'h5A);

    // response stall with continuous requests
    bus.rsp_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      set_req(0, 3'($urandom), 1'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
              8'($urandom));
      if (k >= 2) begin
        #1;
        chk_eq("stall_ready", bus.req_ready, 2'b00);
      end
      step();
    end
    bus.rsp_ready = 1'b1;
    idle();
    repeat (3) step();

    // reset with both stages full, then a chained ADD must see zero carries
    bus.rsp_ready = 1'b0;
    set_req(0, 3'd0, 1'b0, 8'hFF, 8'hFF, 8'hFF, 8'hFF);
    step();
    set_req(0, 3'd0, 1'b0, 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
    step();
    idle();
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
    chk_eq("post_rst_valid", bus.rsp_valid, 1'b0);
    run_one(3'd0, 1'b1, 8'h00, 8'h00, 8'h00, 8'h00, cw, cz, d, co, id);
    chk_eq("post_rst_cin", {cz, cw}, 4'h0);
    chk_eq("post_rst_data", d, 8'h00);

    // randomized traffic with occasional reset
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 199) == 0) begin
        idle();
        reset = 1'b1;
      end else begin
        reset = 1'b0;
        bus.req_valid = 2'($urandom);
        bus.req_cmd   = 6'($urandom);
        bus.req_chain = 2'($urandom);
        bus.req_w = 16'($urandom);
        bus.req_x = 16'($urandom);
        bus.req_y = 16'($urandom);
        bus.req_z = 16'($urandom);
      end
      bus.rsp_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    reset = 1'b0;
    idle();
    bus.rsp_ready = 1'b1;
    repeat (4) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
